// File: rtl/vga_timing.sv
// ============================================================================
//  Module      : vga_timing
//  Description : VGA raster timing generator. Horizontal and vertical pixel
//                counters with matching porch/sync state machines, registered
//                hPixel/line/video_active/hSync/vSync and a one-clock
//                frame_start pulse. Timing advances only on pix_en.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] hPixel,
  output logic [9:0] line,
  output logic       video_active,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_start
);

  // Totals must fit the 10-bit counters (each total <= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Counter values at which each region begins.
  localparam logic [9:0] C_H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] C_H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] C_H_BP_START   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] C_V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] C_V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] C_V_BP_START   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    HS_ACT  = 2'd0,
    HS_FP   = 2'd1,
    HS_SYNC = 2'd2,
    HS_BP   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    VS_ACT  = 2'd0,
    VS_FP   = 2'd1,
    VS_SYNC = 2'd2,
    VS_BP   = 2'd3
  } v_state_t;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  h_state_t   hst_q, hst_d;
  v_state_t   vst_q, vst_d;
  logic       h_wrap;
  logic       frame_wrap;

  logic       video_q, video_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       fs_q, fs_d;

  // Next counter values, state transitions and next output values. Outputs
  // are derived from the next state so they land on the same edge as the
  // counters; a held pix_en therefore leaves every output unchanged, except
  // frame_start which only survives the single wrap edge.
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    hst_d      = hst_q;
    vst_d      = vst_q;
    h_wrap     = 1'b0;
    frame_wrap = 1'b0;

    if (pix_en) begin
      if (h_q == C_H_LAST) begin
        h_d    = '0;
        h_wrap = 1'b1;
      end else begin
        h_d = h_q + 10'd1;
      end

      if (h_wrap) begin
        if (v_q == C_V_LAST) begin
          v_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end

      case (hst_q)
        HS_ACT:  if (h_d == C_H_FP_START)   hst_d = HS_FP;
        HS_FP:   if (h_d == C_H_SYNC_START) hst_d = HS_SYNC;
        HS_SYNC: if (h_d == C_H_BP_START)   hst_d = HS_BP;
        HS_BP:   if (h_wrap)                hst_d = HS_ACT;
        default:                            hst_d = HS_ACT;
      endcase

      // Vertical regions only change on a line boundary.
      if (h_wrap) begin
        case (vst_q)
          VS_ACT:  if (v_d == C_V_FP_START)   vst_d = VS_FP;
          VS_FP:   if (v_d == C_V_SYNC_START) vst_d = VS_SYNC;
          VS_SYNC: if (v_d == C_V_BP_START)   vst_d = VS_BP;
          VS_BP:   if (frame_wrap)            vst_d = VS_ACT;
          default:                            vst_d = VS_ACT;
        endcase
      end
    end

    video_d = (hst_d == HS_ACT) && (vst_d == VS_ACT);
    hsync_d = (hst_d == HS_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = (vst_d == VS_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
    fs_d    = frame_wrap;
  end

  // Timing state and registered outputs; reset aborts to the top-left idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hst_q   <= HS_ACT;
      vst_q   <= VS_ACT;
      video_q <= 1'b1;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hst_q   <= hst_d;
      vst_q   <= vst_d;
      video_q <= video_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign hPixel       = h_q;
  assign line         = v_q;
  assign video_active = video_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign frame_start  = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Directed self-checking bench for vga_timing. A default
//                640x480 instance covers the horizontal timing; a tiny
//                15x8 instance with active-high syncs covers whole frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing;

  logic       clk;
  logic       reset;
  logic       pix_en;

  logic [9:0] d_h, d_l;
  logic       d_va, d_hs, d_vs, d_fs;
  logic [9:0] s_h, s_l;
  logic       s_va, s_hs, s_vs, s_fs;

  int checks = 0;
  int errors = 0;

  vga_timing dut_def (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hPixel(d_h), .line(d_l), .video_active(d_va),
    .hSync(d_hs), .vSync(d_vs), .frame_start(d_fs)
  );

  // Small raster: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), 120 clks/frame.
  vga_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_sm (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hPixel(s_h), .line(s_l), .video_active(s_va),
    .hSync(s_hs), .vSync(s_vs), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (d_h !== 10'd0 || d_l !== 10'd0 || d_va !== 1'b1 || d_hs !== 1'b1 ||
        d_vs !== 1'b1 || d_fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_def: got h=%0d l=%0d va=%b hs=%b vs=%b fs=%b expected 0 0 1 1 1 0",
               d_h, d_l, d_va, d_hs, d_vs, d_fs);
    end
    checks++;
    if (s_h !== 10'd0 || s_l !== 10'd0 || s_va !== 1'b1 || s_hs !== 1'b0 ||
        s_vs !== 1'b0 || s_fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_sm: got h=%0d l=%0d va=%b hs=%b vs=%b fs=%b expected 0 0 1 0 0 0",
               s_h, s_l, s_va, s_hs, s_vs, s_fs);
    end
  endtask

  // 640 enabled clocks after reset land on the first front-porch pixel.
  task automatic test_hactive;
    reset = 1'b0;
    repeat (640) @(posedge clk);
    #1;
    checks++;
    if (d_h !== 10'd640 || d_l !== 10'd0 || d_va !== 1'b0 || d_hs !== 1'b1) begin
      errors++;
      $display("FAIL hactive_end: got h=%0d l=%0d va=%b hs=%b expected 640 0 0 1",
               d_h, d_l, d_va, d_hs);
    end
  endtask

  // Sweep the rest of line 0 and into line 1, checking sync and blanking.
  task automatic test_hsync;
    int low_cnt = 0;
    int bad     = 0;
    for (int i = 0; i < 200; i++) begin
      int eh;
      int el;
      logic ehs;
      logic eva;
      @(posedge clk);
      #1;
      eh  = (641 + i) % 800;
      el  = (641 + i >= 800) ? 1 : 0;
      ehs = (eh >= 656 && eh <= 751) ? 1'b0 : 1'b1;
      eva = (eh < 640);
      if (d_hs === 1'b0) low_cnt++;
      if (d_h !== 10'(eh) || d_l !== 10'(el) || d_hs !== ehs || d_va !== eva) begin
        bad++;
        if (bad <= 3)
          $display("FAIL hsync_sweep: got h=%0d l=%0d hs=%b va=%b expected %0d %0d %b %b",
                   d_h, d_l, d_hs, d_va, eh, el, ehs, eva);
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (low_cnt != 96) begin
      errors++;
      $display("FAIL hsync_width: got %0d low clks expected 96", low_cnt);
    end
  endtask

  // Two full small frames against a count-based reference.
  task automatic test_small_frame;
    int eh = 0;
    int ev = 0;
    int bad = 0;
    int vs_cnt = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 240; i++) begin
      logic efs;
      logic eva;
      logic ehs;
      logic evs;
      @(posedge clk);
      #1;
      efs = 1'b0;
      eh++;
      if (eh == 15) begin
        eh = 0;
        ev++;
        if (ev == 8) begin
          ev  = 0;
          efs = 1'b1;
        end
      end
      eva = (eh < 8) && (ev < 4);
      ehs = (eh >= 10 && eh <= 12);
      evs = (ev >= 5 && ev <= 6);
      if (s_vs === 1'b1) vs_cnt++;
      if (s_h !== 10'(eh) || s_l !== 10'(ev) || s_va !== eva || s_hs !== ehs ||
          s_vs !== evs || s_fs !== efs) begin
        bad++;
        if (bad <= 3)
          $display("FAIL small_frame: got h=%0d l=%0d va=%b hs=%b vs=%b fs=%b expected %0d %0d %b %b %b %b",
                   s_h, s_l, s_va, s_hs, s_vs, s_fs, eh, ev, eva, ehs, evs, efs);
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (vs_cnt != 60) begin
      errors++;
      $display("FAIL vsync_width: got %0d active clks expected 60", vs_cnt);
    end
  endtask

  // Continuous enable: pulses 120 clks apart, at (0,0), one clk wide.
  task automatic test_frame_spacing;
    int last = -1;
    int npulse = 0;
    int bad = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      if (s_fs === 1'b1) begin
        npulse++;
        if (s_h !== 10'd0 || s_l !== 10'd0) begin
          bad++;
          $display("FAIL fs_position: got h=%0d l=%0d expected 0 0", s_h, s_l);
        end
        if (last >= 0 && cyc - last != 120) begin
          bad++;
          $display("FAIL fs_spacing: got %0d expected 120", cyc - last);
        end
        last = cyc;
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (npulse != 3) begin
      errors++;
      $display("FAIL fs_count: got %0d expected 3", npulse);
    end
  endtask

  // Alternating enable: spacing doubles and disabled cycles freeze outputs.
  task automatic test_pix_toggle;
    logic [9:0] ph, pl;
    logic pva, phs, pvs;
    int last = -1;
    int npulse = 0;
    int bad = 0;
    ph = s_h; pl = s_l; pva = s_va; phs = s_hs; pvs = s_vs;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic en;
      en = (cyc % 2 == 0);
      pix_en = en;
      @(posedge clk);
      #1;
      if (!en) begin
        if (s_h !== ph || s_l !== pl || s_va !== pva || s_hs !== phs ||
            s_vs !== pvs || s_fs !== 1'b0) begin
          bad++;
          if (bad <= 3)
            $display("FAIL hold: got h=%0d l=%0d va=%b hs=%b vs=%b fs=%b expected %0d %0d %b %b %b 0",
                     s_h, s_l, s_va, s_hs, s_vs, s_fs, ph, pl, pva, phs, pvs);
        end
      end
      if (s_fs === 1'b1) begin
        npulse++;
        if (last >= 0 && cyc - last != 240) begin
          bad++;
          $display("FAIL toggle_spacing: got %0d expected 240", cyc - last);
        end
        last = cyc;
      end
      ph = s_h; pl = s_l; pva = s_va; phs = s_hs; pvs = s_vs;
    end
    pix_en = 1'b1;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (npulse != 4) begin
      errors++;
      $display("FAIL toggle_count: got %0d expected 4", npulse);
    end
  endtask

  // Asynchronous reset mid-frame, then a full frame before the next pulse.
  task automatic test_reset_mid;
    int n = 0;
    int cnt = 0;
    while (!(s_h == 10'd5 && s_l == 10'd3) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL reach_mid: got timeout expected h=5 l=3");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (s_h !== 10'd0 || s_l !== 10'd0 || s_va !== 1'b1 || s_hs !== 1'b0 ||
        s_vs !== 1'b0 || s_fs !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_sm: got h=%0d l=%0d va=%b hs=%b vs=%b fs=%b expected 0 0 1 0 0 0",
               s_h, s_l, s_va, s_hs, s_vs, s_fs);
    end
    checks++;
    if (d_h !== 10'd0 || d_l !== 10'd0 || d_va !== 1'b1 || d_hs !== 1'b1 ||
        d_vs !== 1'b1 || d_fs !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_def: got h=%0d l=%0d va=%b hs=%b vs=%b fs=%b expected 0 0 1 1 1 0",
               d_h, d_l, d_va, d_hs, d_vs, d_fs);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    while (s_fs !== 1'b1 && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checks++;
    if (cnt != 120) begin
      errors++;
      $display("FAIL post_reset_fs: got %0d clks expected 120", cnt);
    end
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    test_reset;
    test_hactive;
    test_hsync;
    test_small_frame;
    test_frame_spacing;
    test_pix_toggle;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
